// File: rtl/mem_principal_wb.sv
// Backing main memory behind the cache: a small write-back FIFO plus a
// fixed-latency array port. Queued write-backs drain before any read starts.
module mem_principal_wb #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int LATENCY   = 3,
  parameter int WBQ_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic              busy
);

  localparam int WORDS = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(WBQ_DEPTH + 1);
  localparam int PTR_W = (WBQ_DEPTH > 1) ? $clog2(WBQ_DEPTH) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(WBQ_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WBQ_DEPTH - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  cnt;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] mem [WORDS];

  logic [ADDR_W-1:0] q_addr [WBQ_DEPTH];
  logic [DATA_W-1:0] q_data [WBQ_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // The head entry is popped only when its array write completes, so an
  // in-flight write still occupies a FIFO slot and holds off wb_ready.
  always_comb begin
    wb_ready = (count < DEPTH);
    push     = wb_req && wb_ready;
    pop      = (state == WRITE) && (cnt == {LAT_W{1'b0}});
  end

  // Write-back FIFO storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        q_addr[tail] <= wb_addr;
        q_data[tail] <= wb_data;
        tail         <= next_ptr(tail);
      end else begin
        tail <= tail;
      end
      if (pop) begin
        head <= next_ptr(head);
      end else begin
        head <= head;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Access FSM; also owns the array so reset can restore mem[i] = i.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= {LAT_W{1'b0}};
      raddr    <= {ADDR_W{1'b0}};
      rd_valid <= 1'b0;
      rd_data  <= {DATA_W{1'b0}};
      busy     <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= DATA_W'(i);
      end
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (count != {CNT_W{1'b0}}) begin
            state <= WRITE;
            cnt   <= LAT_INIT;
            busy  <= 1'b1;
          end else if (rd_req) begin
            raddr <= rd_addr;
            state <= READ;
            cnt   <= LAT_INIT;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        WRITE: begin
          if (cnt != {LAT_W{1'b0}}) begin
            cnt <= cnt - LAT_W'(1);
          end else begin
            mem[q_addr[head]] <= q_data[head];
            state             <= IDLE;
            busy              <= 1'b0;
          end
        end
        READ: begin
          if (cnt != {LAT_W{1'b0}}) begin
            cnt <= cnt - LAT_W'(1);
          end else begin
            rd_data  <= mem[raddr];
            rd_valid <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_principal_wb.sv
// Directed and randomized checks of mem_principal_wb; a LATENCY=3 instance
// carries most tests and a LATENCY=1 instance covers the short-latency case.
module tb_mem_principal_wb;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rd_req = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       wb_req = 1'b0;
  logic [3:0] wb_addr = 4'h0;
  logic [7:0] wb_data = 8'h00;
  logic       wb_ready;
  logic       busy;

  logic       rd_req1 = 1'b0;
  logic [3:0] rd_addr1 = 4'h0;
  logic       rd_valid1;
  logic [7:0] rd_data1;
  logic       wb_req1 = 1'b0;
  logic [3:0] wb_addr1 = 4'h0;
  logic [7:0] wb_data1 = 8'h00;
  logic       wb_ready1;
  logic       busy1;

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_mem [16];

  always #5 clock = ~clock;

  mem_principal_wb #(.ADDR_W(4), .DATA_W(8), .LATENCY(3), .WBQ_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .busy(busy)
  );

  mem_principal_wb #(.ADDR_W(4), .DATA_W(8), .LATENCY(1), .WBQ_DEPTH(2)) dut1 (
    .clock(clock), .reset(reset),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_valid(rd_valid1), .rd_data(rd_data1),
    .wb_req(wb_req1), .wb_addr(wb_addr1), .wb_data(wb_data1), .wb_ready(wb_ready1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds rd_req until rd_valid; cyc counts cycles from raising rd_req.
  task automatic read3(input logic [3:0] a, output logic [7:0] d,
                       output int cyc, output int bcyc);
    rd_req  = 1'b1;
    rd_addr = a;
    cyc  = 0;
    bcyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (busy) bcyc++;
    end while (!rd_valid && cyc < 100);
    check("rd_valid_seen", {31'd0, rd_valid}, 32'd1);
    d = rd_data;
    rd_req = 1'b0;
  endtask

  // Holds wb_req until the FIFO takes the entry.
  task automatic push3(input logic [3:0] a, input logic [7:0] d);
    int n;
    wb_req  = 1'b1;
    wb_addr = a;
    wb_data = d;
    n = 0;
    while (!wb_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("push_accepted", {31'd0, wb_ready}, 32'd1);
    @(negedge clock);
    wb_req = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int cyc;
    int bcyc;
    bit seen;

    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i);

    // 1: reset state, then a plain read of address 5
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wb_ready", {31'd0, wb_ready}, 32'd1);
    check("rst_wb_ready1", {31'd0, wb_ready1}, 32'd1);
    read3(4'h5, d, cyc, bcyc);
    check("t1_data", {24'd0, d}, 32'h05);
    check("t1_latency", cyc, 32'd4);
    check("t1_busy_cycles", bcyc, 32'd3);

    // 2: queued write-back drains before a read of the same address
    wb_req = 1'b1; wb_addr = 4'h3; wb_data = 8'hAA;
    @(negedge clock);
    wb_req = 1'b0;
    read3(4'h3, d, cyc, bcyc);
    check("t2_data", {24'd0, d}, 32'hAA);
    check("t2_latency", cyc, 32'd8);

    // 3: three consecutive pushes, the third meets a full FIFO
    wb_req = 1'b1; wb_addr = 4'h9; wb_data = 8'h11;
    check("t3_ready_a", {31'd0, wb_ready}, 32'd1);
    @(negedge clock);
    check("t3_ready_b", {31'd0, wb_ready}, 32'd1);
    wb_addr = 4'hA; wb_data = 8'h22;
    @(negedge clock);
    check("t3_full", {31'd0, wb_ready}, 32'd0);
    wb_addr = 4'hB; wb_data = 8'h33;
    @(negedge clock);
    check("t3_still_full", {31'd0, wb_ready}, 32'd0);
    wb_req = 1'b0;
    read3(4'hB, d, cyc, bcyc);
    check("t3_dropped", {24'd0, d}, 32'h0B);
    read3(4'h9, d, cyc, bcyc);
    check("t3_first", {24'd0, d}, 32'h11);
    read3(4'hA, d, cyc, bcyc);
    check("t3_second", {24'd0, d}, 32'h22);

    // 4: push on the write-completion edge keeps the count at 1
    wb_req = 1'b1; wb_addr = 4'hC; wb_data = 8'h44;
    @(negedge clock);
    wb_req = 1'b0;
    repeat (3) @(negedge clock);
    wb_req = 1'b1; wb_addr = 4'hD; wb_data = 8'h55;
    @(negedge clock);
    check("t4_count_kept", {31'd0, wb_ready}, 32'd1);
    wb_addr = 4'hE; wb_data = 8'h66;
    @(negedge clock);
    check("t4_then_full", {31'd0, wb_ready}, 32'd0);
    wb_req = 1'b0;
    read3(4'hC, d, cyc, bcyc);
    check("t4_c", {24'd0, d}, 32'h44);
    read3(4'hD, d, cyc, bcyc);
    check("t4_d", {24'd0, d}, 32'h55);
    read3(4'hE, d, cyc, bcyc);
    check("t4_e", {24'd0, d}, 32'h66);

    // 5: reset in the second cycle of a read aborts it and flushes state
    push3(4'h7, 8'h77);
    read3(4'h7, d, cyc, bcyc);
    check("t5_pre", {24'd0, d}, 32'h77);
    rd_req = 1'b1; rd_addr = 4'h7;
    @(negedge clock);
    wb_req = 1'b1; wb_addr = 4'h1; wb_data = 8'hF1;
    @(negedge clock);
    wb_req = 1'b0; rd_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_rd_data", {24'd0, rd_data}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_wb_ready", {31'd0, wb_ready}, 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (rd_valid) seen = 1'b1;
    end
    check("t5_no_rd_valid", {31'd0, seen}, 32'd0);
    read3(4'h1, d, cyc, bcyc);
    check("t5_fifo_flushed", {24'd0, d}, 32'h01);
    read3(4'h7, d, cyc, bcyc);
    check("t5_mem_reinit", {24'd0, d}, 32'h07);

    // Random write-back bursts followed by reads, against an array model
    for (int it = 0; it < 25; it++) begin
      int np;
      logic [3:0] a;
      logic [7:0] v;
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        a = 4'($urandom_range(0, 5));
        v = 8'($urandom);
        push3(a, v);
        ref_mem[a] = v;
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      read3(a, d, cyc, bcyc);
      check("rand_read", {24'd0, d}, {24'd0, ref_mem[a]});
    end

    // 6: LATENCY=1 instance, single read then back-to-back with rd_req held
    rd_req1 = 1'b1; rd_addr1 = 4'h2;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!rd_valid1 && cyc < 20);
    check("t6_latency", cyc, 32'd2);
    check("t6_data", {24'd0, rd_data1}, 32'h02);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("t6_b2b_pulse", {31'd0, rd_valid1}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    rd_req1 = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
